// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared constants and types for the 5-stage RV32I pipeline front end.
//   XLEN        : PC / datapath width
//   NOP_INSTR   : bubble encoding (addi x0,x0,0)
//   RS1_LSB / RS2_LSB / REG_ADDR_W : register-field positions in an instruction
//   fetch_state_e : fetch-stage sequencing states
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          RS1_LSB    = 15;
    localparam int          RS2_LSB    = 20;
    localparam int          REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_fetch_stage_pc_next_gen.sv
// ---------------------------------------------------------------------------
// pc_next_gen
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc             in  current PC
//   redirect_valid in  taken branch/jump from EX (highest priority)
//   redirect_pc    in  redirect target, forced to word alignment here
//   advance        in  step to the sequential PC (pc + 4, wraps modulo 2^XLEN)
//   pc_next        out PC for the next cycle (holds when neither is asserted)
// ---------------------------------------------------------------------------
module pc_next_gen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc_next
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};
    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc & ALIGN_MASK;
        end else if (advance) begin
            pc_next = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_id_fetch_stage
// Instruction fetch stage plus the IF/ID pipeline register. Owns the PC,
// drives instruction memory, parks a fetched word in a skid register while
// the load-use stall detector holds the pipe, and flushes IF/ID to a NOP
// bubble on a redirect from EX.
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   pc_write_en               1 = advance, 0 = hold PC and IF/ID
//   redirect_valid/_pc        taken branch/jump target from EX
//   imem_req/_addr            fetch request and word-aligned address
//   imem_rdata/_ready         returned instruction, valid when ready=1
//   if_id_pc/_instr/_valid    IF/ID register contents
//   if_id_rs1/_rs2            source register fields, 0 when IF/ID invalid
// Build option FETCH_PERF_CNT_EN adds saturating counters:
//   perf_stall_cnt            cycles with pc_write_en=0 and no redirect
//   perf_flush_cnt            redirect cycles
// ---------------------------------------------------------------------------
module if_id_fetch_stage
    import pipeline_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_write_en,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  imem_req,
    output logic [XLEN-1:0]       imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_ready,
    output logic [XLEN-1:0]       if_id_pc,
    output logic [31:0]           if_id_instr,
    output logic                  if_id_valid,
    output logic [REG_ADDR_W-1:0] if_id_rs1,
    output logic [REG_ADDR_W-1:0] if_id_rs2
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     skid_q, skid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            advance;

    pc_next_gen #(.XLEN(XLEN)) u_pc_next_gen (
        .pc             (pc_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc_next        (pc_d)
    );

    // Redirect beats stall beats memory response. A redirect also drops any
    // word returned in the same cycle, since it belongs to the wrong path.
    always_comb begin
        state_d       = state_q;
        skid_d        = skid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        advance       = 1'b0;

        if (redirect_valid) begin
            state_d       = S_FETCH;
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_BOOT: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready && pc_write_en) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = imem_rdata;
                        if_id_valid_d = 1'b1;
                        advance       = 1'b1;
                    end else if (imem_ready) begin
                        // Park the word; memory would otherwise lose it.
                        skid_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else if (pc_write_en) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = NOP_INSTR;
                        if_id_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (pc_write_en) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = skid_q;
                        if_id_valid_d = 1'b1;
                        advance       = 1'b1;
                        state_d       = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_BOOT;
                end
            endcase
        end

        imem_req_d = (state_d == S_FETCH);
    end

    // Sequencing state and the registered request strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC[XLEN-1:0];
            skid_q        <= '0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            skid_q        <= skid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_rs1   = if_id_valid_q ? if_id_instr_q[RS1_LSB +: REG_ADDR_W] : '0;
    assign if_id_rs2   = if_id_valid_q ? if_id_instr_q[RS2_LSB +: REG_ADDR_W] : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (!redirect_valid && !pc_write_en && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
        if (redirect_valid && (perf_flush_cnt_q != 32'hFFFF_FFFF)) begin
            perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I pipeline; sits directly upstream of the load-use stall detector.
- Owns the PC, drives instruction memory, and holds the fetched instruction when the stall detector's pc_write_en (clk_gate) is low.
- Flushes to a NOP bubble on a taken-branch/jump redirect from EX.
- Exposes if_id_rs1/if_id_rs2 to the stall detector.

Parameters:
- XLEN, 32, PC/data width.
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_write_en  in  1  from stall detector clk_gate; 1 = advance, 0 = hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump resolved in EX.
- redirect_pc  in  XLEN  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (word aligned).
- imem_rdata  in  32  instruction; valid only when imem_ready=1.
- imem_ready  in  1  fetch complete this cycle (may be same cycle as req, or later).
- if_id_pc  out  XLEN  PC of the instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_rs1  out  5  if_id_instr[19:15]; 0 when !if_id_valid.
- if_id_rs2  out  5  if_id_instr[24:20]; 0 when !if_id_valid.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, skid empty, state=S_BOOT, imem_req=0.
- States:
  - S_BOOT: one cycle after reset release, no request; then go to S_FETCH.
  - S_FETCH: imem_req=1, imem_addr=pc.
  - S_HOLD: fetched word parked in skid register; imem_req=0.
- Priority per cycle: redirect_valid > pc_write_en > imem_ready.
- Redirect, any state (overrides stall):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - IF/ID <= {0, NOP_INSTR, valid=0}; skid discarded; any concurrent imem_rdata dropped.
  - state <= S_FETCH. In S_BOOT, the redirect is taken and the boot cycle ends.
- S_FETCH:
  - ready & write_en: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4; stay.
  - ready & !write_en: skid <= imem_rdata; pc unchanged; IF/ID unchanged; go to S_HOLD.
  - !ready & write_en: IF/ID <= {pc, NOP_INSTR, 0} (bubble); pc unchanged.
  - !ready & !write_en: all hold.
- S_HOLD:
  - write_en: IF/ID <= {pc, skid, 1}; pc <= pc+4; go to S_FETCH.
  - else: hold.
- Latency: fetched word reaches IF/ID on the edge ending the imem_ready cycle; sustained 1 instr/cycle with zero-wait memory.
- PC arithmetic: modulo 2^XLEN; pc=FFFF_FFFC increments to 0000_0000. pc[1:0] is always 0.
- Memory may abandon an outstanding request when imem_addr changes; the stage never waits on a stale response.
- Reset mid-S_HOLD or mid-wait: skid contents lost, no IF/ID update, resumes from RESET_PC.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] (cycles with pc_write_en=0 and no redirect) and perf_flush_cnt[31:0] (redirect cycles).
  - Both reset to 0 and saturate at FFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared pipeline_pkg: XLEN, NOP_INSTR, fetch state enum (S_BOOT/S_FETCH/S_HOLD), RS1_LSB=15, RS2_LSB=20, REG_ADDR_W=5.
- One sub-module: pc_next_gen (combinational next-PC mux: redirect / pc+4 / hold, with alignment masking).

Test Plan:
- Reset, RESET_PC=0x100, imem_ready tied 1, pc_write_en=1 -> S_BOOT one cycle, then if_id_pc = 0x100, 0x104, 0x108 on consecutive edges, valid=1.
- Load-use stall: pc_write_en=0 for 2 cycles while ready=1 at pc=0x108 -> IF/ID holds 0x104 entry, state S_HOLD, imem_req=0. On release, IF/ID = {0x108, skid word}, then 0x10C.
- Redirect during stall: pc_write_en=0, redirect_valid=1, redirect_pc=0x203 -> IF/ID valid=0 with NOP_INSTR, rs1=rs2=0, next fetch at 0x200.
- Slow memory: imem_ready low 3 cycles with write_en=1 -> three bubbles (valid=0), pc constant, imem_addr stable.
- Wrap: redirect to 0xFFFF_FFFC, then advance -> next imem_addr=0x0000_0000.
- Async reset asserted mid-S_HOLD between clock edges -> outputs reset immediately without a clock edge.
- With FETCH_PERF_CNT_EN: 5 stall cycles and 2 redirects -> perf_stall_cnt=5, perf_flush_cnt=2.
